// File: rtl/acc_result_streamer_if.sv
// AXI4-Stream bundle carrying averaged result words from the streamer to the DMA.
`timescale 1ns/1ps

interface acc_result_streamer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                      TVALID;
    logic                      TREADY;
    logic [DATA_WIDTH-1:0]     TDATA;
    logic [DATA_WIDTH/8-1:0]   TSTRB;
    logic                      TLAST;

    modport master (
        output TVALID,
        output TDATA,
        output TSTRB,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TDATA,
        input  TSTRB,
        input  TLAST,
        output TREADY
    );
endinterface

// File: rtl/acc_result_streamer.sv
// Result streamer: snoops the accumulator's result-BRAM write port, and once the
// last word of a frame lands it reads the frame back through port B and sends it
// out as one AXI4-Stream packet through a small skid FIFO. Frames that complete
// while a packet is still in progress are dropped and counted.
`timescale 1ns/1ps

module acc_result_streamer #(
    parameter int BRAM_DEPTH = 10,
    parameter int NUM_WORDS  = 1024,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   M_AXIS_ACLK,
    input  logic                   M_AXIS_ARESETN,
    input  logic                   ENABLE,
    input  logic                   RESULT_BRAM_WENABLE,
    input  logic [BRAM_DEPTH-1:0]  RESULT_BRAM_ADDR_WRITE,
    output logic [BRAM_DEPTH-1:0]  RESULT_BRAM_ADDR_READ,
    output logic                   RESULT_BRAM_RENABLE,
    input  logic [DATA_WIDTH-1:0]  RESULT_BRAM_DATAIN,
    acc_result_streamer_if.master  m_axis,
    output logic                   BUSY,
    output logic [31:0]            FRAME_COUNT,
    output logic [15:0]            DROP_COUNT
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [BRAM_DEPTH-1:0] LAST_ADDR = BRAM_DEPTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q;
    logic [BRAM_DEPTH-1:0]  nextAddr_q;
    logic [BRAM_DEPTH-1:0]  addrRead_q;
    logic                   renable_q;
    logic                   rdValid_q;
    logic                   rdLast_q;
    logic [31:0]            frameCount_q;
    logic [15:0]            dropCount_q;

    logic [DATA_WIDTH-1:0]  dataMem_q [FIFO_DEPTH];
    logic                   lastMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr_q;
    logic [PTR_W-1:0]       rdPtr_q;
    logic [CNT_W-1:0]       fifoCount_q;
    logic [CNT_W-1:0]       fifoCount_d;

    logic frameDone;
    logic fifoValid;
    logic push;
    logic pop;
    logic lastHandshake;
    logic issue;

    // Frame detection, FIFO handshake and the read-credit rule: a read may only be
    // issued if every word already in flight plus the FIFO contents still leave room.
    always_comb begin
        frameDone     = RESULT_BRAM_WENABLE && (RESULT_BRAM_ADDR_WRITE == LAST_ADDR);
        fifoValid     = (fifoCount_q != '0);
        push          = rdValid_q;
        pop           = fifoValid && m_axis.TREADY;
        lastHandshake = pop && lastMem_q[rdPtr_q];
        issue         = (state_q == READ) &&
                        ((int'(fifoCount_q) + int'(renable_q) + int'(rdValid_q)) < FIFO_DEPTH);
        fifoCount_d   = fifoCount_q;
        if (push && !pop) begin
            fifoCount_d = fifoCount_q + CNT_W'(1);
        end else if (!push && pop) begin
            fifoCount_d = fifoCount_q - CNT_W'(1);
        end
    end

    // Frame FSM with the registered BRAM read port, read pipeline tracking and counters.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q      <= IDLE;
            nextAddr_q   <= '0;
            addrRead_q   <= '0;
            renable_q    <= 1'b0;
            rdValid_q    <= 1'b0;
            rdLast_q     <= 1'b0;
            frameCount_q <= '0;
            dropCount_q  <= '0;
        end else begin
            renable_q <= issue;
            if (issue) begin
                addrRead_q <= nextAddr_q;
                nextAddr_q <= nextAddr_q + BRAM_DEPTH'(1);
            end
            rdValid_q <= renable_q;
            rdLast_q  <= renable_q && (addrRead_q == LAST_ADDR);

            if (lastHandshake) begin
                frameCount_q <= frameCount_q + 32'd1;
            end
            if (frameDone && (state_q != IDLE) && (dropCount_q != 16'hFFFF)) begin
                dropCount_q <= dropCount_q + 16'd1;
            end

            case (state_q)
                IDLE: begin
                    if (frameDone && ENABLE) begin
                        state_q    <= READ;
                        nextAddr_q <= '0;
                    end
                end
                READ: begin
                    if (issue && (nextAddr_q == LAST_ADDR)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (lastHandshake) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Skid FIFO: read data lands the cycle after RENABLE and leaves on each handshake.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dataMem_q[i] <= '0;
                lastMem_q[i] <= 1'b0;
            end
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (push) begin
                dataMem_q[wrPtr_q] <= RESULT_BRAM_DATAIN;
                lastMem_q[wrPtr_q] <= rdLast_q;
                wrPtr_q            <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            fifoCount_q <= fifoCount_d;
        end
    end

    assign RESULT_BRAM_ADDR_READ = addrRead_q;
    assign RESULT_BRAM_RENABLE   = renable_q;
    assign m_axis.TVALID         = fifoValid;
    assign m_axis.TDATA          = dataMem_q[rdPtr_q];
    assign m_axis.TLAST          = fifoValid && lastMem_q[rdPtr_q];
    assign m_axis.TSTRB          = '1;
    assign BUSY                  = (state_q != IDLE);
    assign FRAME_COUNT           = frameCount_q;
    assign DROP_COUNT            = dropCount_q;

`ifndef SYNTHESIS
    fifoNoOverflow: assert property (@(posedge M_AXIS_ACLK) disable iff (!M_AXIS_ARESETN)
        !(push && !pop && (fifoCount_q == CNT_W'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_acc_result_streamer.sv
// Bench for acc_result_streamer: a BRAM model holding {a, ~a}, a queue-based
// reference of expected beats and counters, vector table plus directed corner cases
// and a randomized phase.
`timescale 1ns/1ps

module tb_acc_result_streamer;

    localparam int BRAM_DEPTH = 10;
    localparam int NUM_WORDS  = 1024;
    localparam int DATA_WIDTH = 64;
    localparam int FIFO_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  enable = 1'b0;
    logic                  wen = 1'b0;
    logic [BRAM_DEPTH-1:0] waddr = '0;
    logic [BRAM_DEPTH-1:0] raddr;
    logic                  renable;
    logic [DATA_WIDTH-1:0] bramDout = '0;
    logic                  busy;
    logic [31:0]           frameCount;
    logic [15:0]           dropCount;

    acc_result_streamer_if #(.DATA_WIDTH(DATA_WIDTH)) axis ();

    acc_result_streamer #(
        .BRAM_DEPTH(BRAM_DEPTH),
        .NUM_WORDS (NUM_WORDS),
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .M_AXIS_ACLK           (clk),
        .M_AXIS_ARESETN        (rst_n),
        .ENABLE                (enable),
        .RESULT_BRAM_WENABLE   (wen),
        .RESULT_BRAM_ADDR_WRITE(waddr),
        .RESULT_BRAM_ADDR_READ (raddr),
        .RESULT_BRAM_RENABLE   (renable),
        .RESULT_BRAM_DATAIN    (bramDout),
        .m_axis                (axis),
        .BUSY                  (busy),
        .FRAME_COUNT           (frameCount),
        .DROP_COUNT            (dropCount)
    );

    always #5 clk = ~clk;

    // Result BRAM port B: synchronous read, data one cycle after the enable
    logic [DATA_WIDTH-1:0] bram [NUM_WORDS];
    always @(posedge clk) if (renable) bramDout <= bram[raddr];

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        bit                    en;
        bit                    we;
        logic [BRAM_DEPTH-1:0] addr;
        bit                    expStart;
    } vec_t;

    beat_t       expQ[$];
    beat_t       nb;
    beat_t       gotBeat;
    bit          modelBusy;
    int          modelFrames;
    int          modelDrops;
    int          beatsDone;
    int          outstanding;
    int          expReadAddr;
    bit          prevStall;
    logic [63:0] prevData;
    logic        prevLast;
    int          readyMode;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [63:0] wordAt(input int a);
        return {32'(a), ~32'(a)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit we, input logic [BRAM_DEPTH-1:0] addr);
        @(posedge clk);
        #1;
        enable = en;
        wen    = we;
        waddr  = addr;
    endtask

    task automatic pulseFrame(input bit en);
        applyStimulus(en, 1'b1, BRAM_DEPTH'(NUM_WORDS - 1));
        applyStimulus(en, 1'b0, '0);
    endtask

    task automatic stepSample();
        @(negedge clk);
        #1;
    endtask

    task automatic clearModel();
        expQ.delete();
        modelBusy   = 0;
        modelFrames = 0;
        modelDrops  = 0;
        beatsDone   = 0;
        outstanding = 0;
        expReadAddr = 0;
        prevStall   = 0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clearModel();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((modelBusy || expQ.size() != 0) && n < budget) begin
            stepSample();
            n++;
        end
        if (modelBusy || expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL frameTimeout: %0d beats still pending after %0d cycles", expQ.size(), budget);
        end
        stepSample();
        checkOutput("busyAfterFrame", busy, 1'b0);
        checkOutput("frameCountModel", frameCount, modelFrames);
        checkOutput("dropCountModel", dropCount, modelDrops);
    endtask

    task automatic waitBeats(input int count, input int budget);
        int n = 0;
        while (beatsDone < count && n < budget) begin
            stepSample();
            n++;
        end
        if (beatsDone < count) begin
            checks++;
            errors++;
            $display("[TB] FAIL beatTimeout: reached %0d beats, wanted %0d", beatsDone, count);
        end
    endtask

    // TREADY pattern generator
    initial begin
        axis.TREADY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       axis.TREADY = 1'b1;
                1:       axis.TREADY = 1'($urandom_range(0, 1));
                default: axis.TREADY = 1'b0;
            endcase
        end
    end

    // Reference model and stream monitor, evaluated between edges
    always @(negedge clk) begin
        if (rst_n) begin
            if (wen && waddr == BRAM_DEPTH'(NUM_WORDS - 1)) begin
                if (modelBusy) begin
                    if (modelDrops < 65535) modelDrops++;
                end else if (enable) begin
                    modelBusy   = 1;
                    expReadAddr = 0;
                    for (int i = 0; i < NUM_WORDS; i++) begin
                        nb.data = wordAt(i);
                        nb.last = (i == NUM_WORDS - 1);
                        expQ.push_back(nb);
                    end
                end
            end
            if (renable) begin
                checkOutput("readAddr", raddr, expReadAddr);
                expReadAddr++;
                outstanding++;
            end
            if (prevStall) begin
                checkOutput("tvalidHeld", axis.TVALID, 1'b1);
                checkOutput("tdataStable", axis.TDATA, prevData);
                checkOutput("tlastStable", axis.TLAST, prevLast);
            end
            if (axis.TVALID && axis.TREADY) begin
                outstanding--;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedBeat: got %0h with no beat expected", axis.TDATA);
                end else begin
                    gotBeat = expQ.pop_front();
                    checkOutput("tdata", axis.TDATA, gotBeat.data);
                    checkOutput("tlast", axis.TLAST, gotBeat.last);
                    beatsDone++;
                    if (gotBeat.last) begin
                        modelBusy = 0;
                        modelFrames++;
                        beatsDone = 0;
                    end
                end
            end
            if (outstanding > FIFO_DEPTH) begin
                checks++;
                errors++;
                $display("[TB] FAIL occupancy: %0d reads outstanding, limit %0d", outstanding, FIFO_DEPTH);
            end
            prevStall = axis.TVALID && !axis.TREADY;
            prevData  = axis.TDATA;
            prevLast  = axis.TLAST;
        end else begin
            prevStall = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t vecs[6];
    bit   curEn;
    int   r;

    initial begin
        for (int a = 0; a < NUM_WORDS; a++) bram[a] = wordAt(a);
        vecs[0] = '{en: 1'b1, we: 1'b1, addr: 10'd1023, expStart: 1'b1};
        vecs[1] = '{en: 1'b1, we: 1'b1, addr: 10'd1022, expStart: 1'b0};
        vecs[2] = '{en: 1'b1, we: 1'b0, addr: 10'd1023, expStart: 1'b0};
        vecs[3] = '{en: 1'b0, we: 1'b1, addr: 10'd1023, expStart: 1'b0};
        vecs[4] = '{en: 1'b1, we: 1'b1, addr: 10'd0,    expStart: 1'b0};
        vecs[5] = '{en: 1'b1, we: 1'b1, addr: 10'd1023, expStart: 1'b1};
        readyMode = 0;
        clearModel();

        // Reset state
        rst_n = 1'b0;
        #12;
        checkOutput("rstTvalid", axis.TVALID, 1'b0);
        checkOutput("rstTlast", axis.TLAST, 1'b0);
        checkOutput("rstTdata", axis.TDATA, 64'h0);
        checkOutput("rstTstrb", axis.TSTRB, 64'hFF);
        checkOutput("rstRenable", renable, 1'b0);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstFrames", frameCount, 0);
        checkOutput("rstDrops", dropCount, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Test 1: three-cycle latency, full frame at TREADY=1
        $display("[TB] test 1: single frame, TREADY high");
        pulseFrame(1'b1);
        for (int k = 0; k < 4; k++) begin
            stepSample();
            checkOutput($sformatf("tvalidLatency%0d", k), axis.TVALID, (k == 3));
        end
        waitIdle(3000);
        checkOutput("t1FrameCount", frameCount, 1);

        // Table of frame_done qualifier vectors, each applied from IDLE
        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].en, vecs[i].we, vecs[i].addr);
            applyStimulus(1'b1, 1'b0, '0);
            stepSample();
            checkOutput($sformatf("vecBusy%0d", i), busy, vecs[i].expStart);
            checkOutput($sformatf("vecDrop%0d", i), dropCount, 0);
            if (vecs[i].expStart) waitIdle(3000);
        end

        // Test 2: random backpressure
        $display("[TB] test 2: random TREADY");
        readyMode = 1;
        pulseFrame(1'b1);
        waitIdle(8000);

        // Test 3: long stall after the first beat
        $display("[TB] test 3: 200-cycle stall");
        readyMode = 0;
        pulseFrame(1'b1);
        waitBeats(1, 100);
        readyMode = 2;
        repeat (200) stepSample();
        checkOutput("stallOutstanding", outstanding, FIFO_DEPTH);
        checkOutput("stallTvalid", axis.TVALID, 1'b1);
        readyMode = 0;
        waitIdle(3000);

        // Test 4: frame_done mid-packet is dropped
        $display("[TB] test 4: drop during packet");
        doReset();
        pulseFrame(1'b1);
        waitBeats(500, 2000);
        pulseFrame(1'b1);
        stepSample();
        checkOutput("t4DropCount", dropCount, 1);
        checkOutput("t4BusyStill", busy, 1'b1);
        waitIdle(3000);
        checkOutput("t4FrameCount1", frameCount, 1);
        pulseFrame(1'b1);
        waitIdle(3000);
        checkOutput("t4FrameCount2", frameCount, 2);
        checkOutput("t4DropCountEnd", dropCount, 1);

        // Test 5: ENABLE low ignores frames, falling mid-frame does not cut it
        $display("[TB] test 5: ENABLE handling");
        doReset();
        pulseFrame(1'b0);
        for (int k = 0; k < 6; k++) begin
            stepSample();
            checkOutput($sformatf("t5NoStream%0d", k), axis.TVALID, 1'b0);
        end
        checkOutput("t5Drops", dropCount, 0);
        checkOutput("t5Busy", busy, 1'b0);
        pulseFrame(1'b1);
        waitBeats(10, 100);
        applyStimulus(1'b0, 1'b0, '0);
        waitIdle(3000);
        checkOutput("t5FrameCount", frameCount, 1);

        // Test 6: reset in the middle of a packet
        $display("[TB] test 6: reset mid-packet");
        applyStimulus(1'b1, 1'b0, '0);
        pulseFrame(1'b1);
        waitBeats(300, 1000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput("t6Tvalid", axis.TVALID, 1'b0);
        checkOutput("t6Tlast", axis.TLAST, 1'b0);
        checkOutput("t6Tdata", axis.TDATA, 64'h0);
        checkOutput("t6Renable", renable, 1'b0);
        checkOutput("t6Busy", busy, 1'b0);
        checkOutput("t6Frames", frameCount, 0);
        checkOutput("t6Raddr", raddr, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        pulseFrame(1'b1);
        waitIdle(3000);
        checkOutput("t6FrameCount", frameCount, 1);
        checkOutput("t6DropCount", dropCount, 0);

        // Randomized phase against the reference model
        $display("[TB] randomized phase");
        readyMode = 1;
        curEn = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            r = $urandom_range(0, 399);
            if ($urandom_range(0, 199) == 0) curEn = !curEn;
            if (r == 0)
                applyStimulus(curEn, 1'b1, 10'd1022);
            else if (r < 3)
                applyStimulus(curEn, 1'b1, 10'd1023);
            else
                applyStimulus(curEn, 1'b0, BRAM_DEPTH'($urandom_range(0, NUM_WORDS - 1)));
        end
        applyStimulus(1'b1, 1'b0, '0);
        waitIdle(8000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
